// File: rtl/clk_div_prog.sv
// Runtime-programmable 50%-duty integer clock divider (even and odd ratios)
// with a source-domain enable tick; all changes land on period boundaries.
module clk_div_prog #(
    parameter int CNT_W       = 8,
    parameter int DEFAULT_DIV = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [CNT_W-1:0] div_ratio,
    input  logic             div_load,
    output logic             div_ack,
    output logic             div_err,
    output logic [CNT_W-1:0] cur_ratio,
    output logic             running,
    output logic             clk_out,
    output logic             clk_en_tick
);

    localparam logic [CNT_W-1:0] DEF_R = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO   = CNT_W'(2);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cur_q, cur_d;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic             pend_v_q, pend_v_d;
    logic             run_q, run_d;
    logic             p_q, p_d;
    logic             odd_q, odd_d;
    logic             tick_q, tick_d;
    logic             ack_q, ack_d;
    logic             err_q, err_d;
    logic             n_q;
    logic [CNT_W-1:0] half;
    logic [CNT_W-1:0] cnt_inc;
    logic             last;

    assign half    = cur_q >> 1;
    assign cnt_inc = cnt_q + ONE;
    assign last    = run_q && (cnt_q == cur_q - ONE);

    always_comb begin
        cnt_d    = cnt_q;
        cur_d    = cur_q;
        pend_d   = pend_q;
        pend_v_d = pend_v_q;
        run_d    = run_q;
        p_d      = p_q;
        odd_d    = odd_q;
        tick_d   = 1'b0;
        ack_d    = 1'b0;
        err_d    = 1'b0;

        // Apply before capture so a load in the boundary cycle waits a period
        if (pend_v_q && (!run_q || last)) begin
            cur_d    = pend_q;
            odd_d    = pend_q[0];
            pend_v_d = 1'b0;
            ack_d    = 1'b1;
        end

        if (div_load) begin
            if (div_ratio < TWO) begin
                err_d = 1'b1;
            end else begin
                pend_d   = div_ratio;
                pend_v_d = 1'b1;
            end
        end

        if (!run_q) begin
            if (enable) begin
                run_d  = 1'b1;
                cnt_d  = '0;
                p_d    = 1'b1;
                tick_d = 1'b1;
            end
        end else if (last) begin
            cnt_d = '0;
            if (enable) begin
                p_d    = 1'b1;
                tick_d = 1'b1;
            end else begin
                run_d = 1'b0;
                p_d   = 1'b0;
            end
        end else begin
            cnt_d = cnt_inc;
            p_d   = cnt_inc < half;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            cur_q    <= DEF_R;
            pend_q   <= '0;
            pend_v_q <= 1'b0;
            run_q    <= 1'b0;
            p_q      <= 1'b0;
            odd_q    <= DEF_R[0];
            tick_q   <= 1'b0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            cur_q    <= cur_d;
            pend_q   <= pend_d;
            pend_v_q <= pend_v_d;
            run_q    <= run_d;
            p_q      <= p_d;
            odd_q    <= odd_d;
            tick_q   <= tick_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
        end
    end

    // Half-cycle retime of p_q stretches odd-ratio highs by half a clock
    always_ff @(negedge clk) begin
        if (rst) begin
            n_q <= 1'b0;
        end else begin
            n_q <= p_q;
        end
    end

    // run_q gate lets reset truncate the output without waiting for a negedge
    assign clk_out     = p_q | (odd_q & run_q & n_q);
    assign clk_en_tick = tick_q;
    assign div_ack     = ack_q;
    assign div_err     = err_q;
    assign cur_ratio   = cur_q;
    assign running     = run_q;

endmodule
